adder_seq_ctrl: RTL

Sequencer that drives one full_adder tile to perform multi-precision (multi-limb) additions, one width-bit limb at a time, LSB limb first.
- Accepts an operation request, streams operand limbs in, and arms the tile per limb.
- Chains carry_out of limb n into carry_in of limb n+1.
- Returns per-limb sums on a valid/ready result stream.
- Sits between the CGRA tile's operand routing and the full_adder instance; owns the tile's on_off and carry_listen controls.

---
 rtl/adder_seq_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
//
// Sequencer for a single full_adder tile performing multi-limb additions,
// one width-bit limb per pass, least significant limb first.  The carry out
// of each limb is held in r_carry and fed back as the carry in of the next.
//
// Optional feature (compile-time macro ADDSEQ_SUB_EN):
//   defined   - adds input req_sub; a request with req_sub=1 computes A-B
//               (operand B inverted per limb, carry into limb 0 forced to 1).
//               res_carry=1 on the last beat means no borrow.
//   undefined - add-only; req_sub does not exist.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   req_*              operation request (valid/ready, limb count, carry in)
//   op_*               operand limb stream (valid/ready, a, b)
//   res_*              result limb stream (valid/ready, sum, carry, last)
//   busy               controller is not idle
//   fa_a/fa_b          operands presented to the tile
//   fa_carry_in        carry presented to the tile while it is armed
//   fa_carry_listen    tile should consume fa_carry_in
//   fa_on_off          tile enable (high only while executing a limb)
//   fa_c/fa_carry_out  tile sum and carry
//   fa_ack             tile has accepted the carry and its result is valid
// -----------------------------------------------------------------------------
module adder_seq_ctrl #(
    parameter int unsigned width     = 16,
    parameter int unsigned max_words = 4,
    parameter int unsigned cnt_w     = $clog2(max_words) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [cnt_w-1:0] req_words,
    input  logic             req_carry_in,
`ifdef ADDSEQ_SUB_EN
    input  logic             req_sub,
`endif
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [width-1:0] op_a,
    input  logic [width-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [width-1:0] res_sum,
    output logic             res_carry,
    output logic             res_last,
    output logic             busy,
    output logic [width-1:0] fa_a,
    output logic [width-1:0] fa_b,
    output logic             fa_carry_in,
    output logic             fa_carry_listen,
    output logic             fa_on_off,
    input  logic [width-1:0] fa_c,
    input  logic             fa_carry_out,
    input  logic             fa_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [cnt_w-1:0] MAX_W = cnt_w'(max_words);

    state_t           r_state;
    state_t           w_next;

    logic             r_req_ready;
    logic             r_op_ready;
    logic             r_res_valid;

    logic [cnt_w-1:0] r_words;
    logic [cnt_w-1:0] r_idx;
    logic             r_carry;
    logic [width-1:0] r_fa_a;
    logic [width-1:0] r_fa_b;
    logic [width-1:0] r_res_sum;
    logic             r_res_carry;
    logic             r_res_last;
`ifdef ADDSEQ_SUB_EN
    logic             r_sub;
`endif

    logic [cnt_w-1:0] w_words;
    logic             w_req_fire;
    logic             w_op_fire;
    logic             w_res_fire;

    // A limb count of zero or beyond the limit means a full-length operation.
    assign w_words = ((req_words == '0) || (req_words > MAX_W)) ? MAX_W : req_words;

    // The ready/valid registers are only ever high in their own state, so
    // they double as state qualifiers for the handshakes.
    assign w_req_fire = req_valid & r_req_ready;
    assign w_op_fire  = op_valid & r_op_ready;
    assign w_res_fire = r_res_valid & res_ready;

    // State register, with the handshake outputs registered from the next
    // state so they are low during reset and rise one edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == IDLE);
            r_op_ready  <= (w_next == FETCH);
            r_res_valid <= (w_next == RESP);
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_req_fire) w_next = FETCH;
            FETCH: if (w_op_fire)  w_next = EXEC;
            EXEC:  if (fa_ack)     w_next = RESP;
            RESP:  if (w_res_fire) w_next = r_res_last ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers: request context, tile operands, captured result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_words     <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_fa_a      <= '0;
            r_fa_b      <= '0;
            r_res_sum   <= '0;
            r_res_carry <= 1'b0;
            r_res_last  <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_words <= w_words;
                        r_idx   <= '0;
`ifdef ADDSEQ_SUB_EN
                        // Subtraction is A + ~B + 1: the +1 enters as limb 0 carry.
                        r_sub   <= req_sub;
                        r_carry <= req_sub | req_carry_in;
`else
                        r_carry <= req_carry_in;
`endif
                    end
                end
                FETCH: begin
                    if (w_op_fire) begin
                        r_fa_a <= op_a;
`ifdef ADDSEQ_SUB_EN
                        r_fa_b <= r_sub ? ~op_b : op_b;
`else
                        r_fa_b <= op_b;
`endif
                    end
                end
                EXEC: begin
                    if (fa_ack) begin
                        r_res_sum   <= fa_c;
                        r_res_carry <= fa_carry_out;
                        r_carry     <= fa_carry_out;
                        r_res_last  <= (r_idx == (r_words - cnt_w'(1)));
                    end
                end
                RESP: begin
                    if (w_res_fire && !r_res_last) begin
                        r_idx <= r_idx + cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        busy            = (r_state != IDLE);
        fa_on_off       = (r_state == EXEC);
        fa_carry_listen = (r_state == EXEC);
        fa_carry_in     = (r_state == EXEC) ? r_carry : 1'b0;
    end

    assign req_ready = r_req_ready;
    assign op_ready  = r_op_ready;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_carry = r_res_carry;
    assign res_last  = r_res_last;
    assign fa_a      = r_fa_a;
    assign fa_b      = r_fa_b;

endmodule
